// File: rtl/logic_reduce_seq.sv
// Sequential bitwise reducer: folds up to PORT_NUM operands (AND/OR/XOR/NAND) from a valid/ready stream.
// Optional abort input enabled by defining LOGIC_REDUCE_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start; no operands accepted
// ACCUM | accepting operands and folding them into acc
// DONE  | result held on out_data until out_ready
module logic_reduce_seq #(
  parameter int WIDTH    = 8,
  parameter int PORT_NUM = 8,
  parameter int CNT_W    = $clog2(PORT_NUM + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
`ifdef LOGIC_REDUCE_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             accept;
  logic             term;
  logic             abort_hit;

`ifdef LOGIC_REDUCE_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    accept    = in_valid & in_ready;
    count_nxt = count + CNT_W'(1);
    term      = in_last | (count_nxt == CNT_W'(PORT_NUM));
    fold      = acc;
    // NAND folds as AND; the inversion is applied only to the delivered result
    case (op_q)
      OP_AND, OP_NAND: fold = acc & in_data;
      OP_OR:           fold = acc | in_data;
      OP_XOR:          fold = acc ^ in_data;
      default:         fold = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_AND;
      acc       <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            acc      <= (op == OP_AND || op == OP_NAND) ? '1 : '0;
            count    <= '0;
            state    <= ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (abort_hit) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            acc      <= '0;
            count    <= '0;
          end else if (accept) begin
            acc   <= fold;
            count <= count_nxt;
            if (term) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= (op_q == OP_NAND) ? ~fold : fold;
              out_count <= count_nxt;
            end
          end
        end
        DONE: begin
          if (abort_hit) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            count     <= '0;
          end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_reduce_seq.sv
// Self-checking bench for logic_reduce_seq: directed scenarios plus randomized reductions
// compared against a per-bit population-count reference model.
module tb_logic_reduce_seq;

  localparam int WIDTH    = 8;
  localparam int PORT_NUM = 8;
  localparam int CNT_W    = $clog2(PORT_NUM + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] words [PORT_NUM];

  logic_reduce_seq #(.WIDTH(WIDTH), .PORT_NUM(PORT_NUM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
`ifdef LOGIC_REDUCE_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per bit: count how many operands have a 1, then apply the operation's truth rule.
  function automatic logic [WIDTH-1:0] ref_fold(input logic [1:0] o, input int n);
    logic [WIDTH-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int k = 0; k < n; k++) ones += int'(words[k][b]);
      case (o)
        2'b00: r[b] = (ones == n);
        2'b01: r[b] = (ones > 0);
        2'b10: r[b] = (ones % 2 == 1);
        default: r[b] = (ones != n);
      endcase
    end
    return r;
  endfunction

  // last_idx < 0 means no in_last; gap_mode 0 none, 1 one idle cycle between beats, 2 random 0..2
  task automatic run_txn(input string tag, input logic [1:0] o, input int last_idx,
                         input int gap_mode, input int hold);
    int n_fold;
    int gaps;
    logic [WIDTH-1:0] exp_d;
    n_fold = (last_idx >= 0 && last_idx < PORT_NUM) ? last_idx + 1 : PORT_NUM;
    exp_d  = ref_fold(o, n_fold);
    start = 1'b1; op = o;
    step();
    start = 1'b0;
    chk({tag, " busy_accum"}, busy, 1);
    chk({tag, " ready_accum"}, in_ready, 1);
    for (int i = 0; i < n_fold; i++) begin
      gaps = 0;
      if (i > 0 && gap_mode == 1) gaps = 1;
      if (gap_mode == 2) gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0; in_data = WIDTH'($urandom); in_last = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, " gap_ready"}, in_ready, 1);
        chk({tag, " gap_valid"}, out_valid, 0);
      end
      in_valid = 1'b1; in_data = words[i]; in_last = (i == last_idx);
      step();
      if (i < n_fold - 1) begin
        chk({tag, " mid_valid"}, out_valid, 0);
        chk({tag, " mid_ready"}, in_ready, 1);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " ready_done"}, in_ready, 0);
    chk({tag, " out_data"}, out_data, exp_d);
    chk({tag, " out_count"}, out_count, n_fold);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; in_valid = 1'b1;
      step();
      chk({tag, " hold_valid"}, out_valid, 1);
      chk({tag, " hold_data"}, out_data, exp_d);
      chk({tag, " hold_count"}, out_count, n_fold);
    end
    in_valid = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    chk({tag, " valid_drop"}, out_valid, 0);
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " idle_ready"}, in_ready, 0);
    step();
    chk({tag, " start_ignored"}, busy, 0);
  endtask

  initial begin
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    repeat (3) step();
    chk("idle_valid busy", busy, 0);
    chk("idle_valid in_ready", in_ready, 0);
    chk("idle_valid out_valid", out_valid, 0);
    in_valid = 1'b0; in_last = 1'b0;

    words[0] = 8'hFF; words[1] = 8'hF0; words[2] = 8'h3C;
    run_txn("and3", 2'b00, 2, 0, 0);
    chk("and3 model", ref_fold(2'b00, 3), 8'h30);

    for (int i = 0; i < PORT_NUM; i++) words[i] = 8'h01;
    run_txn("xor8", 2'b10, -1, 0, 0);

    words[0] = 8'hAA;
    run_txn("nand1", 2'b11, 0, 0, 5);

    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h04;
    run_txn("or_gap", 2'b01, 2, 1, 1);

    // asynchronous reset in the middle of a reduction
    start = 1'b1; op = 2'b01;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hF0;
    step();
    in_data = 8'h0C;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid out_valid", out_valid, 0);
    chk("rst_mid out_data", out_data, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    words[0] = 8'h0F;
    run_txn("and_after_rst", 2'b00, 0, 0, 0);

`ifdef LOGIC_REDUCE_ABORT_EN
    start = 1'b1; op = 2'b00;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hF3; in_last = 1'b1; abort = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0; abort = 1'b0;
    chk("abort out_valid", out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort in_ready", in_ready, 0);
    words[0] = 8'h10;
    run_txn("or_after_abort", 2'b01, 0, 0, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      int li;
      for (int i = 0; i < PORT_NUM; i++) begin
        words[i] = WIDTH'($urandom);
        if ($urandom_range(0, 3) == 0) words[i] = 8'hFF;
      end
      li = $urandom_range(0, PORT_NUM + 1);
      if (li >= PORT_NUM) li = -1;
      run_txn("rand", 2'($urandom_range(0, 3)), li, 2, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
